// File: rtl/lcd1602_pkg.sv
// Shared LCD1602 definitions: HD44780 command bytes, bus-writer states,
// default 50 MHz timings and the long-execution command classifier.
package lcd1602_pkg;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_DDRAM_L1  = 8'h80;
    localparam logic [7:0] CMD_DDRAM_L2  = 8'hC0;

    localparam int unsigned DEF_T_POWERUP_CYC   = 2_000_000;
    localparam int unsigned DEF_T_SETUP_CYC     = 4;
    localparam int unsigned DEF_T_EN_HIGH_CYC   = 15;
    localparam int unsigned DEF_T_HOLD_CYC      = 4;
    localparam int unsigned DEF_T_EXEC_CYC      = 2_500;
    localparam int unsigned DEF_T_EXEC_LONG_CYC = 80_000;

    typedef enum logic [2:0] {
        BW_POWERUP = 3'd0,
        BW_IDLE    = 3'd1,
        BW_SETUP   = 3'd2,
        BW_PULSE   = 3'd3,
        BW_HOLD    = 3'd4,
        BW_EXEC    = 3'd5
    } bw_state_e;

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd1602_bus_writer.sv
// HD44780 8-bit write engine: takes one RS/byte over valid/ready and plays it
// onto the LCD pins with setup, E-high, hold and execution-wait timing.
module lcd1602_bus_writer
    import lcd1602_pkg::*;
#(
    parameter int unsigned T_POWERUP_CYC   = DEF_T_POWERUP_CYC,
    parameter int unsigned T_SETUP_CYC     = DEF_T_SETUP_CYC,
    parameter int unsigned T_EN_HIGH_CYC   = DEF_T_EN_HIGH_CYC,
    parameter int unsigned T_HOLD_CYC      = DEF_T_HOLD_CYC,
    parameter int unsigned T_EXEC_CYC      = DEF_T_EXEC_CYC,
    parameter int unsigned T_EXEC_LONG_CYC = DEF_T_EXEC_LONG_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_POWERUP_CYC, T_SETUP_CYC),
                                                max_u(T_EN_HIGH_CYC, T_HOLD_CYC)),
                                          max_u(T_EXEC_CYC, T_EXEC_LONG_CYC));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    // Terminal count of a phase; a zero-length phase is stretched to one cycle.
    function automatic logic [CNT_W-1:0] last_cnt(input int unsigned t);
        return (t <= 1) ? '0 : CNT_W'(t - 1);
    endfunction

    localparam logic [CNT_W-1:0] LAST_PWR       = last_cnt(T_POWERUP_CYC);
    localparam logic [CNT_W-1:0] LAST_SETUP     = last_cnt(T_SETUP_CYC);
    localparam logic [CNT_W-1:0] LAST_EN        = last_cnt(T_EN_HIGH_CYC);
    localparam logic [CNT_W-1:0] LAST_HOLD      = last_cnt(T_HOLD_CYC);
    localparam logic [CNT_W-1:0] LAST_EXEC      = last_cnt(T_EXEC_CYC);
    localparam logic [CNT_W-1:0] LAST_EXEC_LONG = last_cnt(T_EXEC_LONG_CYC);

    bw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       dat_q, dat_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             take;
    logic [CNT_W-1:0] exec_last;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        rs_d      = rs_q;
        dat_d     = dat_q;
        en_d      = en_q;
        take      = in_valid && ready_q;
        exec_last = is_long_cmd(rs_q, dat_q) ? LAST_EXEC_LONG : LAST_EXEC;

        case (state_q)
            BW_POWERUP: begin
                if (cnt_q == LAST_PWR) begin
                    state_d = BW_IDLE;
                    cnt_d   = '0;
                end
            end
            BW_IDLE: cnt_d = '0;
            BW_SETUP: begin
                if (cnt_q == LAST_SETUP) begin
                    state_d = BW_PULSE;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            BW_PULSE: begin
                if (cnt_q == LAST_EN) begin
                    state_d = BW_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            BW_HOLD: begin
                if (cnt_q == LAST_HOLD) begin
                    state_d = BW_EXEC;
                    cnt_d   = '0;
                end
            end
            BW_EXEC: begin
                if (cnt_q == exec_last) begin
                    state_d = BW_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = BW_POWERUP;
                cnt_d   = '0;
            end
        endcase

        // ready_q is only high in IDLE or the last EXEC cycle, so this covers
        // both a fresh transfer and a back-to-back one with no idle bubble.
        if (take) begin
            state_d = BW_SETUP;
            cnt_d   = '0;
            rs_d    = in_rs;
            dat_d   = in_data;
        end

        // in_ready rises during the final EXEC cycle so the next transfer edge
        // lands exactly setup+en+hold+exec cycles after the previous one.
        ready_d = (state_d == BW_IDLE) || (state_d == BW_EXEC && cnt_d == exec_last);
        busy_d  = (state_d != BW_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BW_POWERUP;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = en_q;
    assign lcd_dat  = dat_q;

endmodule

// File: doc/lcd1602_bus_writer.md
Name: lcd1602_bus_writer

Overview:
- Physical-bus write engine for an HD44780-compatible LCD1602 in 8-bit write-only mode.
- Accepts one command/data byte at a time over a valid/ready handshake.
- Drives RS/DB[7:0]/E with programmable setup, enable-high, hold and execution-wait times. Also enforces the post-power-up wait.
- Sits directly downstream of the init/text sequencer, which feeds it the 0x38/0x0C/0x06/0x01/0x80/character stream. Sits directly upstream of the LCD pins.

Parameters:
- T_POWERUP_CYC, 2_000_000, cycles after reset before the first write (40 ms at 50 MHz).
- T_SETUP_CYC, 4, cycles RS/DB are stable before E rises.
- T_EN_HIGH_CYC, 15, cycles E is held high.
- T_HOLD_CYC, 4, cycles RS/DB are held after E falls.
- T_EXEC_CYC, 2_500, execution wait for normal commands/data (50 us).
- T_EXEC_LONG_CYC, 80_000, execution wait for clear/home (1.6 ms).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream byte available
- in_ready  out  1  engine can accept a byte this cycle
- in_rs  in  1  0 = command, 1 = data
- in_data  in  8  byte to write
- busy  out  1  high whenever not in IDLE
- lcd_rs  out  1  LCD RS pin
- lcd_rw  out  1  LCD RW pin, constant 0
- lcd_en  out  1  LCD E pin
- lcd_dat  out  8  LCD DB[7:0]

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values: lcd_en=0, lcd_rs=0, lcd_dat=0x00, lcd_rw=0, in_ready=0, busy=1, state=POWERUP, counter=0.
- States: POWERUP, IDLE, SETUP, PULSE, HOLD, EXEC. One down/up counter is shared across states. Its width is a localparam, clog2 of the largest timing parameter plus 1.
- POWERUP: count T_POWERUP_CYC cycles, then enter IDLE. in_ready goes to 1 exactly T_POWERUP_CYC edges after the last edge sampling rst=1.
- IDLE: in_ready=1, busy=0.
  - Transfer occurs on an edge where in_valid & in_ready.
  - On that edge: capture in_rs/in_data into lcd_rs/lcd_dat, clear in_ready, set busy, enter SETUP.
  - in_valid without in_ready is ignored, no queueing. Upstream must hold in_rs/in_data stable until the transfer.
- SETUP: lcd_en=0 for T_SETUP_CYC cycles, then enter PULSE.
- PULSE: lcd_en=1 for exactly T_EN_HIGH_CYC cycles, then enter HOLD.
- HOLD: lcd_en=0. lcd_rs/lcd_dat stay unchanged for T_HOLD_CYC cycles, then enter EXEC.
- EXEC: wait T_EXEC_LONG_CYC if the captured rs=0 and data is 0x01, 0x02 or 0x03 (clear/home). Otherwise wait T_EXEC_CYC. Then enter IDLE.
- lcd_rs/lcd_dat keep the last written value until the next transfer. They change only on a transfer edge, never while lcd_en=1.
- Latency: transfer edge k → lcd_en rises at edge k+S, falls at k+S+E. in_ready reasserts at k+S+E+H+X, where S/E/H/X are the setup/en-high/hold/exec cycle counts.
- Throughput: at most one byte per S+E+H+X cycles. No bubble is added beyond that.
- Any timing parameter set to 0 behaves as 1.
- Reset mid-operation (including during PULSE): the next edge forces the reset values, so lcd_en drops immediately. The in-flight byte is discarded and the power-up wait restarts.
- in_valid asserted during POWERUP or busy: no effect, no error.

Decomposition:
- Shared package lcd1602_pkg holds:
  - Command constants: CMD_FUNC_8B2L=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY_INC=0x06, CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_DDRAM_L1=0x80, CMD_DDRAM_L2=0xC0.
  - Bus-writer state enum.
  - Default timing constants for 50 MHz.
  - An is_long_cmd(rs, data) function, reused by the sequencer.
- No sub-module is warranted. The counter and FSM stay inline.

Test Plan:
All scenarios use T_POWERUP=10, SETUP=2, EN_HIGH=3, HOLD=2, EXEC=5, EXEC_LONG=20.
1. Release rst, hold in_valid=1 → in_ready stays 0 for 10 cycles and rises on the 10th edge. lcd_en=0 throughout.
2. Send rs=1, data=0x48 ('H') → lcd_rs=1 and lcd_dat=0x48 the edge after transfer. lcd_en is high for exactly 3 cycles, starting 2 cycles after transfer. in_ready returns 12 cycles after transfer.
3. Send rs=0, data=0x01 → in_ready returns 27 cycles after transfer. Repeat with data=0x38 → returns after 12.
4. Back-to-back: keep in_valid=1 through the sequence 0x38, 0x0C, 0x06, 0x80 → four E pulses with transfers exactly 12 cycles apart. lcd_dat is never changed while lcd_en=1.
5. Assert rst for one cycle during the 2nd PULSE cycle → lcd_en=0, lcd_dat=0x00 and in_ready=0 on the next edge. A fresh 10-cycle power-up follows, and there is no residual pulse.
6. Toggle in_valid with in_data changing while busy → no extra E pulse. lcd_dat is unchanged until the next IDLE transfer.
